// File: rtl/shield_oc_guard_pkg.sv
// Shared definitions for the shield over-current guard: channel states,
// register word indices, register bit positions and the block ID.
package shield_oc_guard_pkg;

  typedef enum logic [1:0] {
    ST_OK   = 2'd0,
    ST_QUAL = 2'd1,
    ST_TRIP = 2'd2,
    ST_COOL = 2'd3
  } chan_state_e;

  localparam logic [1:0] REG_STATUS = 2'd0;
  localparam logic [1:0] REG_CTRL   = 2'd1;
  localparam logic [1:0] REG_COUNT  = 2'd2;
  localparam logic [1:0] REG_ID     = 2'd3;

  localparam int KILL_LSB   = 0;
  localparam int STICKY_LSB = 8;
  localparam int LIVE_LSB   = 16;
  localparam int IRQEN_LSB  = 0;
  localparam int RETRY_LSB  = 8;
  localparam int CNTB_LSB   = 8;

  localparam logic [31:0] GUARD_ID = 32'h0C6A_0001;

endpackage

// File: rtl/shield_oc_guard_chan.sv
// One over-current channel: pin synchroniser, qualify/trip/cool-down FSM
// and the saturating trip counter.
module oc_guard_chan
  import shield_oc_guard_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 1000,
  parameter int COOL_CYCLES     = 1000000,
  parameter int CNT_W           = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             ocn_raw_i,
  input  logic             retry_en_i,
  input  logic             w1c_i,
  input  logic             cnt_clr_i,
  output logic             sync_o,
  output logic             kill_o,
  output logic             filt_o,
  output logic             trip_o,
  output logic [CNT_W-1:0] trip_cnt_o
);

  localparam logic [15:0]      DEB_LAST  = 16'(DEBOUNCE_CYCLES);
  localparam logic [23:0]      COOL_LAST = 24'(COOL_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [1:0]       sync_q;
  chan_state_e      state_q, state_d;
  logic [15:0]      deb_q, deb_d;
  logic [23:0]      cool_q, cool_d;
  logic             kill_q, kill_d;
  logic             filt_q;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_base_s;
  logic             trip_s;
  logic             s_s;

  assign s_s = sync_q[1];

  // Synchroniser idles high so reset can never look like a fault.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sync_q <= 2'b11;
    end else begin
      sync_q <= {sync_q[0], ocn_raw_i};
    end
  end

  // Channel FSM next state, debounce and cool-down counting.
  always_comb begin
    state_d = state_q;
    deb_d   = deb_q;
    cool_d  = cool_q;
    trip_s  = 1'b0;
    case (state_q)
      ST_OK: begin
        if (!s_s) begin
          state_d = ST_QUAL;
          deb_d   = 16'd1;
        end else begin
          state_d = ST_OK;
        end
      end
      ST_QUAL: begin
        if (s_s) begin
          state_d = ST_OK;
        end else if (deb_q == DEB_LAST) begin
          state_d = ST_TRIP;
          trip_s  = 1'b1;
        end else begin
          deb_d = deb_q + 16'd1;
        end
      end
      ST_TRIP: begin
        if (retry_en_i || w1c_i) begin
          state_d = ST_COOL;
          cool_d  = 24'd0;
        end else begin
          state_d = ST_TRIP;
        end
      end
      ST_COOL: begin
        if (cool_q == COOL_LAST) begin
          // A fault still present at the end of cool-down restarts it silently.
          cool_d  = 24'd0;
          state_d = s_s ? ST_OK : ST_COOL;
        end else begin
          cool_d = cool_q + 24'd1;
        end
      end
      default: begin
        state_d = ST_OK;
      end
    endcase
    kill_d = (state_d == ST_TRIP) || (state_d == ST_COOL);
  end

  // Trip counter: a clear and a trip in the same cycle leaves one trip counted.
  always_comb begin
    if (cnt_clr_i) begin
      cnt_base_s = '0;
    end else begin
      cnt_base_s = cnt_q;
    end
    if (trip_s && (cnt_base_s != CNT_MAX)) begin
      cnt_d = cnt_base_s + CNT_ONE;
    end else begin
      cnt_d = cnt_base_s;
    end
  end

  // Channel state registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= ST_OK;
      deb_q   <= 16'd0;
      cool_q  <= 24'd0;
      kill_q  <= 1'b0;
      filt_q  <= 1'b1;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      deb_q   <= deb_d;
      cool_q  <= cool_d;
      kill_q  <= kill_d;
      filt_q  <= ~kill_d;
      cnt_q   <= cnt_d;
    end
  end

  assign sync_o     = s_s;
  assign kill_o     = kill_q;
  assign filt_o     = filt_q;
  assign trip_o     = trip_s;
  assign trip_cnt_o = cnt_q;

endmodule

// File: rtl/shield_oc_guard.sv
// Over-current guard for both shield ports: two channels, Avalon-MM
// register file, maskable interrupt and PWREN override.
module shield_oc_guard
  import shield_oc_guard_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 1000,
  parameter int COOL_CYCLES     = 1000000,
  parameter int CNT_W           = 8
) (
  input  logic        csi_MCLK_clk,
  input  logic        rsi_MRST_reset,
  input  logic [1:0]  avs_ctrl_address,
  input  logic [31:0] avs_ctrl_writedata,
  output logic [31:0] avs_ctrl_readdata,
  input  logic [3:0]  avs_ctrl_byteenable,
  input  logic        avs_ctrl_write,
  input  logic        avs_ctrl_read,
  output logic        avs_ctrl_waitrequest,
  output logic        ins_GUARD_irq,
  input  logic        coe_A_OCN_raw,
  input  logic        coe_B_OCN_raw,
  output logic        coe_A_OCN_filt,
  output logic        coe_B_OCN_filt,
  input  logic        coe_A_PWREN_in,
  input  logic        coe_B_PWREN_in,
  output logic        coe_A_PWREN,
  output logic        coe_B_PWREN
);

  logic [1:0]       kill_s, sync_s, trip_s, w1c_s;
  logic [1:0]       sticky_q, sticky_d;
  logic [1:0]       irq_en_q, irq_en_d;
  logic [1:0]       retry_en_q, retry_en_d;
  logic             irq_q;
  logic             cnt_clr_s;
  logic             wr_status_s, wr_ctrl_s;
  logic [CNT_W-1:0] cnt_a_s, cnt_b_s;
  logic [31:0]      rdata_s;
  logic             unused_ok_s;

  oc_guard_chan #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .COOL_CYCLES(COOL_CYCLES), .CNT_W(CNT_W)
  ) u_chan_a (
    .clk_i(csi_MCLK_clk), .rst_i(rsi_MRST_reset), .ocn_raw_i(coe_A_OCN_raw),
    .retry_en_i(retry_en_q[0]), .w1c_i(w1c_s[0]), .cnt_clr_i(cnt_clr_s),
    .sync_o(sync_s[0]), .kill_o(kill_s[0]), .filt_o(coe_A_OCN_filt),
    .trip_o(trip_s[0]), .trip_cnt_o(cnt_a_s)
  );

  oc_guard_chan #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .COOL_CYCLES(COOL_CYCLES), .CNT_W(CNT_W)
  ) u_chan_b (
    .clk_i(csi_MCLK_clk), .rst_i(rsi_MRST_reset), .ocn_raw_i(coe_B_OCN_raw),
    .retry_en_i(retry_en_q[1]), .w1c_i(w1c_s[1]), .cnt_clr_i(cnt_clr_s),
    .sync_o(sync_s[1]), .kill_o(kill_s[1]), .filt_o(coe_B_OCN_filt),
    .trip_o(trip_s[1]), .trip_cnt_o(cnt_b_s)
  );

  assign wr_status_s = avs_ctrl_write && (avs_ctrl_address == REG_STATUS);
  assign wr_ctrl_s   = avs_ctrl_write && (avs_ctrl_address == REG_CTRL);
  assign cnt_clr_s   = avs_ctrl_write && (avs_ctrl_address == REG_COUNT) && avs_ctrl_byteenable[0];
  assign w1c_s       = (wr_status_s && avs_ctrl_byteenable[1]) ?
                       avs_ctrl_writedata[STICKY_LSB +: 2] : 2'b00;

  // Register next state; a new trip beats a same-cycle W1C.
  always_comb begin
    sticky_d = (sticky_q & ~w1c_s) | trip_s;
    if (wr_ctrl_s && avs_ctrl_byteenable[0]) begin
      irq_en_d = avs_ctrl_writedata[IRQEN_LSB +: 2];
    end else begin
      irq_en_d = irq_en_q;
    end
    if (wr_ctrl_s && avs_ctrl_byteenable[1]) begin
      retry_en_d = avs_ctrl_writedata[RETRY_LSB +: 2];
    end else begin
      retry_en_d = retry_en_q;
    end
  end

  // Register file and interrupt flop.
  always_ff @(posedge csi_MCLK_clk or posedge rsi_MRST_reset) begin
    if (rsi_MRST_reset) begin
      sticky_q   <= 2'b00;
      irq_en_q   <= 2'b00;
      retry_en_q <= 2'b00;
      irq_q      <= 1'b0;
    end else begin
      sticky_q   <= sticky_d;
      irq_en_q   <= irq_en_d;
      retry_en_q <= retry_en_d;
      irq_q      <= |(sticky_q & irq_en_q);
    end
  end

  // Read mux; reads have no side effects.
  always_comb begin
    rdata_s = 32'h0000_0000;
    case (avs_ctrl_address)
      REG_STATUS: begin
        rdata_s[KILL_LSB +: 2]   = kill_s;
        rdata_s[STICKY_LSB +: 2] = sticky_q;
        rdata_s[LIVE_LSB +: 2]   = ~sync_s;
      end
      REG_CTRL: begin
        rdata_s[IRQEN_LSB +: 2] = irq_en_q;
        rdata_s[RETRY_LSB +: 2] = retry_en_q;
      end
      REG_COUNT: begin
        rdata_s[0 +: CNT_W]        = cnt_a_s;
        rdata_s[CNTB_LSB +: CNT_W] = cnt_b_s;
      end
      REG_ID: begin
        rdata_s = GUARD_ID;
      end
      default: begin
        rdata_s = 32'h0000_0000;
      end
    endcase
  end

  assign avs_ctrl_readdata    = rdata_s;
  assign avs_ctrl_waitrequest = 1'b0;
  assign ins_GUARD_irq        = irq_q;
  assign coe_A_PWREN          = coe_A_PWREN_in | kill_s[0];
  assign coe_B_PWREN          = coe_B_PWREN_in | kill_s[1];

  assign unused_ok_s = ^{avs_ctrl_read, avs_ctrl_writedata[31:10],
                         avs_ctrl_writedata[7:2], avs_ctrl_byteenable[3:2]};

endmodule

// File: tb/tb_shield_oc_guard.sv
// Self-checking bench for shield_oc_guard: behavioural model compared every
// cycle, plus directed literal checks for glitch, trip, recovery, retry,
// saturation, collisions and async reset.
module tb_shield_oc_guard;

  localparam int DEB = 4;
  localparam int COOL = 8;
  localparam logic [31:0] ID_VAL = 32'h0C6A_0001;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [1:0]  avs_ctrl_address = 2'd0;
  logic [31:0] avs_ctrl_writedata = 32'h0;
  logic [31:0] avs_ctrl_readdata;
  logic [3:0]  avs_ctrl_byteenable = 4'h0;
  logic        avs_ctrl_write = 1'b0;
  logic        avs_ctrl_read = 1'b0;
  logic        avs_ctrl_waitrequest;
  logic        irq;
  logic [1:0]  raw_v = 2'b11;
  logic [1:0]  pwin_v = 2'b00;
  logic        filt_a, filt_b, pwren_a, pwren_b;

  always #5 clk = ~clk;

  shield_oc_guard #(.DEBOUNCE_CYCLES(DEB), .COOL_CYCLES(COOL), .CNT_W(8)) dut (
    .csi_MCLK_clk(clk), .rsi_MRST_reset(rst),
    .avs_ctrl_address(avs_ctrl_address), .avs_ctrl_writedata(avs_ctrl_writedata),
    .avs_ctrl_readdata(avs_ctrl_readdata), .avs_ctrl_byteenable(avs_ctrl_byteenable),
    .avs_ctrl_write(avs_ctrl_write), .avs_ctrl_read(avs_ctrl_read),
    .avs_ctrl_waitrequest(avs_ctrl_waitrequest), .ins_GUARD_irq(irq),
    .coe_A_OCN_raw(raw_v[0]), .coe_B_OCN_raw(raw_v[1]),
    .coe_A_OCN_filt(filt_a), .coe_B_OCN_filt(filt_b),
    .coe_A_PWREN_in(pwin_v[0]), .coe_B_PWREN_in(pwin_v[1]),
    .coe_A_PWREN(pwren_a), .coe_B_PWREN(pwren_b)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  bit m_s1 [2], m_s2 [2];
  int m_run [2], m_cool [2], m_cnt [2];
  bit m_off [2], m_cooling [2], m_sticky [2], m_irq_en [2], m_retry [2];
  bit m_irq;

  task automatic model_reset();
    for (int c = 0; c < 2; c++) begin
      m_s1[c] = 1'b1; m_s2[c] = 1'b1; m_run[c] = 0; m_cool[c] = 0; m_cnt[c] = 0;
      m_off[c] = 1'b0; m_cooling[c] = 1'b0; m_sticky[c] = 1'b0;
      m_irq_en[c] = 1'b0; m_retry[c] = 1'b0;
    end
    m_irq = 1'b0;
  endtask

  task automatic model_step();
    bit w1c [2];
    bit clr, nxt_irq, trip, s, wr_ctrl;
    for (int c = 0; c < 2; c++)
      w1c[c] = avs_ctrl_write && (avs_ctrl_address == 2'd0) && avs_ctrl_byteenable[1]
               && avs_ctrl_writedata[8+c];
    clr = avs_ctrl_write && (avs_ctrl_address == 2'd2) && avs_ctrl_byteenable[0];
    wr_ctrl = avs_ctrl_write && (avs_ctrl_address == 2'd1);
    nxt_irq = (m_sticky[0] && m_irq_en[0]) || (m_sticky[1] && m_irq_en[1]);
    for (int c = 0; c < 2; c++) begin
      trip = 1'b0;
      s = m_s2[c];
      if (!m_off[c]) begin
        // a fault needs DEB+1 consecutive low observations
        if (s) m_run[c] = 0;
        else begin
          m_run[c]++;
          if (m_run[c] == DEB + 1) begin
            trip = 1'b1; m_off[c] = 1'b1; m_cooling[c] = 1'b0; m_run[c] = 0;
          end
        end
      end else if (!m_cooling[c]) begin
        if (m_retry[c] || w1c[c]) begin m_cooling[c] = 1'b1; m_cool[c] = 0; end
      end else begin
        m_cool[c]++;
        if (m_cool[c] == COOL) begin
          m_cool[c] = 0;
          if (s) begin m_off[c] = 1'b0; m_cooling[c] = 1'b0; end
        end
      end
      m_sticky[c] = trip || (m_sticky[c] && !w1c[c]);
      if (clr) m_cnt[c] = 0;
      if (trip && m_cnt[c] < 255) m_cnt[c]++;
    end
    for (int c = 0; c < 2; c++) begin
      if (wr_ctrl && avs_ctrl_byteenable[0]) m_irq_en[c] = avs_ctrl_writedata[c];
      if (wr_ctrl && avs_ctrl_byteenable[1]) m_retry[c] = avs_ctrl_writedata[8+c];
    end
    m_irq = nxt_irq;
    for (int c = 0; c < 2; c++) begin
      m_s2[c] = m_s1[c];
      m_s1[c] = raw_v[c];
    end
  endtask

  function automatic logic [31:0] exp_read(input logic [1:0] a);
    logic [31:0] v;
    v = 32'h0;
    case (a)
      2'd0: begin
        if (m_off[0]) v += 32'h1;
        if (m_off[1]) v += 32'h2;
        if (m_sticky[0]) v += 32'h100;
        if (m_sticky[1]) v += 32'h200;
        if (!m_s2[0]) v += 32'h10000;
        if (!m_s2[1]) v += 32'h20000;
      end
      2'd1: begin
        if (m_irq_en[0]) v += 32'h1;
        if (m_irq_en[1]) v += 32'h2;
        if (m_retry[0]) v += 32'h100;
        if (m_retry[1]) v += 32'h200;
      end
      2'd2: v = 32'(m_cnt[0]) + 32'(m_cnt[1]) * 32'd256;
      default: v = ID_VAL;
    endcase
    return v;
  endfunction

  initial begin
    model_reset();
    forever begin
      @(posedge clk or posedge rst);
      if (rst) model_reset();
      else model_step();
    end
  end

  // Compare every cycle, mid-low-phase.
  initial begin
    forever begin
      @(negedge clk);
      #2;
      check("pwren_a", pwren_a, pwin_v[0] | m_off[0]);
      check("pwren_b", pwren_b, pwin_v[1] | m_off[1]);
      check("filt_a", filt_a, !m_off[0]);
      check("filt_b", filt_b, !m_off[1]);
      check("irq", irq, m_irq);
      check("waitreq", avs_ctrl_waitrequest, 1'b0);
      check("readdata", avs_ctrl_readdata, exp_read(avs_ctrl_address));
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic wr(input logic [1:0] a, input logic [31:0] d, input logic [3:0] be);
    @(negedge clk);
    avs_ctrl_write = 1'b1; avs_ctrl_address = a; avs_ctrl_writedata = d; avs_ctrl_byteenable = be;
    @(negedge clk);
    avs_ctrl_write = 1'b0; avs_ctrl_byteenable = 4'h0;
  endtask

  task automatic rd_chk(input string name, input logic [1:0] a, input logic [31:0] mask,
                        input logic [31:0] exp);
    @(negedge clk);
    avs_ctrl_address = a;
    #1;
    check(name, avs_ctrl_readdata & mask, exp);
  endtask

  // Pin low for 8 edges (trip lands on edge 6), optional write on edge 6.
  task automatic pulse_trip(input int ch, input bit do_wr, input logic [1:0] a,
                            input logic [31:0] d, input logic [3:0] be);
    @(negedge clk);
    raw_v[ch] = 1'b0;
    repeat (6) @(negedge clk);
    if (do_wr) begin
      avs_ctrl_write = 1'b1; avs_ctrl_address = a; avs_ctrl_writedata = d; avs_ctrl_byteenable = be;
    end else begin
      avs_ctrl_write = 1'b0;
    end
    @(negedge clk);
    avs_ctrl_write = 1'b0; avs_ctrl_byteenable = 4'h0;
    @(negedge clk);
    raw_v[ch] = 1'b1;
    repeat (12) @(negedge clk);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int waited;
    #1 rst = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    check("rst_irq", irq, 1'b0);
    check("rst_filt_a", filt_a, 1'b1);
    check("rst_pwren_a", pwren_a, 1'b0);
    #2 rst = 1'b0;
    rd_chk("rst_status", 2'd0, 32'hFFFF_FFFF, 32'h0);
    rd_chk("rst_ctrl", 2'd1, 32'hFFFF_FFFF, 32'h0);
    rd_chk("rst_count", 2'd2, 32'hFFFF_FFFF, 32'h0);
    rd_chk("id", 2'd3, 32'hFFFF_FFFF, ID_VAL);

    // 1. glitch of three cycles is rejected
    @(negedge clk); raw_v[0] = 1'b0;
    repeat (3) @(negedge clk); raw_v[0] = 1'b1;
    repeat (4) @(negedge clk); #1;
    check("glitch_filt", filt_a, 1'b1);
    rd_chk("glitch_status", 2'd0, 32'hFFFF_FFFF, 32'h0);
    rd_chk("glitch_count", 2'd2, 32'hFFFF_FFFF, 32'h0);

    // 2. sustained fault, kill after edge 6, irq one cycle later
    wr(2'd1, 32'h0000_0001, 4'b0001);
    @(negedge clk); raw_v[0] = 1'b0;
    repeat (6) @(negedge clk); #1;
    check("t2_pwren_e5", pwren_a, 1'b0);
    check("t2_filt_e5", filt_a, 1'b1);
    @(negedge clk); #1;
    check("t2_pwren_e6", pwren_a, 1'b1);
    check("t2_filt_e6", filt_a, 1'b0);
    check("t2_irq_e6", irq, 1'b0);
    @(negedge clk); #1;
    check("t2_irq_e7", irq, 1'b1);
    raw_v[0] = 1'b1;
    repeat (3) @(negedge clk);
    rd_chk("t2_status", 2'd0, 32'hFFFF_FFFF, 32'h0000_0101);
    rd_chk("t2_count", 2'd2, 32'hFFFF_FFFF, 32'h0000_0001);

    // 3. W1C releases into cool-down; power back after 8 cool cycles
    wr(2'd0, 32'h0000_0100, 4'b0010);
    #1 check("t3_irq_w", irq, 1'b1);
    @(negedge clk); #1;
    check("t3_irq_w1", irq, 1'b0);
    repeat (6) @(negedge clk); #1;
    check("t3_pwren_w7", pwren_a, 1'b1);
    @(negedge clk); #1;
    check("t3_pwren_w8", pwren_a, 1'b0);
    pwin_v[0] = 1'b1; #1;
    check("t3_follow", pwren_a, 1'b1);
    pwin_v[0] = 1'b0;

    // 4. auto-retry with a persistent fault
    wr(2'd2, 32'h0, 4'b0001);
    wr(2'd1, 32'h0000_0101, 4'b0011);
    @(negedge clk); raw_v[0] = 1'b0;
    repeat (40) @(negedge clk); #1;
    check("t4_kill_held", pwren_a, 1'b1);
    rd_chk("t4_count", 2'd2, 32'h0000_00FF, 32'h1);
    @(negedge clk); raw_v[0] = 1'b1;
    waited = 0;
    while (!filt_a && waited < 20) begin
      @(negedge clk); #1;
      waited++;
    end
    check("t4_release", filt_a, 1'b1);

    // 5. saturation and same-cycle collisions
    for (int i = 0; i < 300; i++) pulse_trip(0, 1'b0, 2'd0, 32'h0, 4'h0);
    rd_chk("t5_sat", 2'd2, 32'h0000_00FF, 32'hFF);
    pulse_trip(0, 1'b1, 2'd2, 32'h0, 4'b0001);
    rd_chk("t5_clr_trip", 2'd2, 32'h0000_00FF, 32'h1);
    pulse_trip(0, 1'b1, 2'd0, 32'h0000_0100, 4'b0010);
    rd_chk("t5_w1c_trip", 2'd0, 32'h0000_0300, 32'h100);

    // 6. async reset during a B trip
    wr(2'd1, 32'h0000_0102, 4'b0011);
    @(negedge clk); raw_v[1] = 1'b0;
    repeat (10) @(negedge clk); #1;
    check("t6_pwren_b_trip", pwren_b, 1'b1);
    check("t6_irq_trip", irq, 1'b1);
    @(negedge clk); #3 rst = 1'b1; #1;
    check("t6_pwren_b_rst", pwren_b, 1'b0);
    check("t6_filt_b_rst", filt_b, 1'b1);
    check("t6_irq_rst", irq, 1'b0);
    rd_chk("t6_status", 2'd0, 32'hFFFF_FFFF, 32'h0);
    rd_chk("t6_ctrl", 2'd1, 32'hFFFF_FFFF, 32'h0);
    rd_chk("t6_count", 2'd2, 32'hFFFF_FFFF, 32'h0);
    rd_chk("t6_id", 2'd3, 32'hFFFF_FFFF, ID_VAL);
    @(negedge clk); #3 rst = 1'b0;
    raw_v[1] = 1'b1;
    repeat (10) @(negedge clk);
    #3;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/shield_oc_guard.md
Name: shield_oc_guard

Overview:
- Over-current front-end for both shield module ports, placed between the raw OCN pins and the shield control block.
- Synchronises and debounces each OCN input, then latches faults into sticky status and a trip counter.
- On a confirmed fault it force-disables module power, overriding the active-low PWREN that the control block drives.
- Provides a cool-down auto-retry timer, a debounced OCN output to feed the control block, and its own maskable IRQ over a small Avalon-MM slave.

Parameters:
- DEBOUNCE_CYCLES, 1000: consecutive synchronised-low cycles needed to confirm a fault (1..65535).
- COOL_CYCLES, 1000000: power-off hold time after a trip before retry (1..2^24-1).
- CNT_W, 8: width of each per-channel trip counter, saturating.

Ports:
- csi_MCLK_clk, in, 1: clock.
- rsi_MRST_reset, in, 1: reset.
- avs_ctrl_address, in, 2: register word select.
- avs_ctrl_writedata, in, 32: write data.
- avs_ctrl_readdata, out, 32: read data, combinational from address.
- avs_ctrl_byteenable, in, 4: byte lanes.
- avs_ctrl_write, in, 1: write strobe.
- avs_ctrl_read, in, 1: read strobe, no side effects.
- avs_ctrl_waitrequest, out, 1: tied 0.
- ins_GUARD_irq, out, 1: level interrupt, registered.
- coe_A_OCN_raw / coe_B_OCN_raw, in, 1 each: pin OCN, active-low, asynchronous.
- coe_A_OCN_filt / coe_B_OCN_filt, out, 1 each: debounced OCN to the control block; low while the channel is in TRIP or COOL.
- coe_A_PWREN_in / coe_B_PWREN_in, in, 1 each: active-low enable from the control block.
- coe_A_PWREN / coe_B_PWREN, out, 1 each: pin drive, equal to PWREN_in OR kill_x (1 = power off).

Behaviour:
- Interface decision: reset rsi_MRST_reset, asynchronous, active-high; clock csi_MCLK_clk.
- Reset values:
  - sync flops = 1; state = OK; all counters = 0; kill = 0.
  - sticky = 0; irq_en = 0; retry_en = 0.
  - irq = 0; OCN_filt = 1.
  - Reset mid-trip releases kill immediately.
- Synchroniser: 2-flop per channel. All logic uses the synced value s_x.
- Per-channel FSM, states OK, QUAL, TRIP, COOL:
  - OK: s_x = 0 -> QUAL, deb_cnt = 1.
  - QUAL:
    - s_x = 1 -> OK (glitch rejected, nothing recorded).
    - deb_cnt == DEBOUNCE_CYCLES -> TRIP: set kill, set sticky_x, trip_cnt_x += 1 (saturating at 2^CNT_W-1).
    - otherwise deb_cnt += 1.
  - TRIP: kill = 1. If retry_en_x, or a software W1C of sticky_x this cycle -> COOL with cool_cnt = 0.
  - COOL: kill = 1, cool_cnt += 1. At cool_cnt == COOL_CYCLES-1:
    - s_x = 1 -> OK (kill drops next cycle);
    - s_x = 0 -> restart COOL, cool_cnt = 0, no new trip counted.
- Latency: with OCN held low, edge 0 is the first edge sampling the pin low. kill and OCN_filt = 0 are visible after edge DEBOUNCE_CYCLES+2.
- Register map:
  - Word 0 STATUS:
    - [1:0] kill B,A (RO);
    - [9:8] sticky B,A, W1C, byte lane 1;
    - [17:16] s_B, s_A inverted, i.e. live fault (RO).
  - Word 1 CTRL, RW:
    - [1:0] irq_en B,A, lane 0;
    - [9:8] retry_en B,A, lane 1.
  - Word 2 COUNT:
    - [CNT_W-1:0] trip_cnt_A, [CNT_W+7:8] trip_cnt_B;
    - any write with lane 0 set clears both.
  - Word 3 ID: RO, reads 32'h0C6A_0001.
  - Writes honour byteenable; unused bits read 0.
- IRQ: ins_GUARD_irq <= |(sticky & irq_en), one-cycle registered.
- Simultaneous events:
  - W1C and a new trip on the same channel in one cycle -> sticky stays 1.
  - COUNT clear and a trip in one cycle -> counter = 1.
  - The two channels are fully independent.

Decomposition:
- Shared package:
  - FSM state enum (OK=0, QUAL=1, TRIP=2, COOL=3);
  - register word indices;
  - bit-position constants;
  - ID constant.
- One sub-module, oc_guard_chan: synchroniser + FSM + debounce/cool/trip counters. Instantiated twice.
- The top holds the register file, IRQ and PWREN muxing.

Test Plan (DEBOUNCE_CYCLES=4, COOL_CYCLES=8):
1. Glitch: A_OCN_raw low for 3 cycles -> no kill, sticky = 0, trip_cnt_A = 0, OCN_filt stays 1.
2. Sustained fault, retry_en = 0: A_OCN_raw low at edge 0 -> A_PWREN = 1 after edge 6 even with PWREN_in = 0; STATUS = 0x101; COUNT[7:0] = 1. With irq_en_A = 1, irq = 1 one cycle later.
3. W1C recovery: after case 2, raise OCN, write STATUS 0x100 -> sticky clears, irq drops; after 8 COOL cycles kill = 0 and A_PWREN follows PWREN_in.
4. Auto-retry with persistent fault: retry_en_A = 1, OCN held low -> COOL repeats, kill held, trip_cnt stays 1. Releasing OCN -> kill clears at the end of the current cool period.
5. Saturation/collision: 300 trips -> trip_cnt = 255. COUNT write in the same cycle as a trip -> 1. W1C same cycle as a trip -> sticky = 1.
6. Async reset asserted during TRIP on B -> immediately kill_B = 0, B_PWREN = PWREN_in, irq = 0, all registers read 0 except ID.
